// File: rtl/fifo_frame_wr_ctrl.sv
// fifo_frame_wr_ctrl: store-and-forward frame admission into the async FIFO; FRAME_WR_STATS_EN adds saturating frame counters
module fifo_frame_wr_ctrl #(
  parameter int DATA_W          = 40,
  parameter int DEPTH_W         = 9,
  parameter int MAX_FRAME_WORDS = 64
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_sop,
  input  logic                s_eop,
  output logic                fifo_wen,
  output logic [DATA_W+3:0]   fifo_wdata,
  input  logic                fifo_wfull,
  input  logic [DEPTH_W:0]    fifo_wr_level,
  output logic                frame_drop,
  output logic                proto_err,
  output logic                ovf_err,
  output logic [31:0]         frame_ok_cnt,
  output logic [31:0]         frame_drop_cnt
);
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAME_WORDS);
  localparam logic [DEPTH_W+1:0] MAX_L = (DEPTH_W + 2)'(MAX_FRAME_WORDS);
  localparam logic [DEPTH_W+1:0] CAP = (DEPTH_W + 2)'(1) << DEPTH_W;
  localparam bit ONE = MAX_FRAME_WORDS == 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_W+3:0] wdata_q, wdata_d;
  logic wen_q, wen_d, drop_q, drop_d, perr_q, perr_d;
  logic [DEPTH_W+1:0] free;
  logic sop_ok, trunc_i, trunc_p;
  // the level lags one write, so the write still in flight is subtracted too
  assign free = CAP - {1'b0, fifo_wr_level} - {{(DEPTH_W + 1){1'b0}}, wen_q};
  assign sop_ok = free >= MAX_L;
  assign cnt_inc = cnt_q == MAX_C ? cnt_q : cnt_q + CW'(1);
  assign trunc_i = ONE && !s_eop;
  assign trunc_p = s_sop || (!s_eop && cnt_inc == MAX_C);
  assign s_ready = 1'b1;
  assign fifo_wen = wen_q;
  assign fifo_wdata = wdata_q;
  assign frame_drop = drop_q;
  assign proto_err = perr_q;
  assign ovf_err = wen_q && fifo_wfull;
  // state and registered FIFO-side outputs
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      drop_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      drop_q  <= drop_d;
      perr_q  <= perr_d;
    end
  end
  // next state: a truncated or interrupted frame drains in DROP until its eop
  always_comb begin
    state_d = state_q;
    if (s_valid)
      case (state_q)
        IDLE:    state_d = (!s_sop || s_eop) ? IDLE : (sop_ok && !ONE) ? PASS : DROP;
        PASS:    state_d = s_eop ? IDLE : trunc_p ? DROP : PASS;
        DROP:    state_d = s_eop ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
  end
  // write, flag packing and pulses for the accepted word
  always_comb begin
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    perr_d  = 1'b0;
    if (s_valid)
      case (state_q)
        IDLE: begin
          perr_d  = !s_sop || (sop_ok && trunc_i);
          drop_d  = s_sop && !sop_ok;
          wen_d   = s_sop && sop_ok;
          cnt_d   = wen_d ? CW'(1) : cnt_q;
          wdata_d = wen_d ? {1'b1, s_eop || trunc_i, trunc_i, 1'b0, s_data} : wdata_q;
        end
        PASS: begin
          wen_d   = 1'b1;
          cnt_d   = cnt_inc;
          perr_d  = trunc_p;
          wdata_d = {1'b0, s_eop || trunc_p, trunc_p, 1'b0, s_data};
        end
        default: ;
      endcase
  end
`ifdef FRAME_WR_STATS_EN
  logic [31:0] ok_q, dcnt_q;
  logic admit;
  assign admit = s_valid && state_q == IDLE && s_sop && sop_ok;
  assign frame_ok_cnt = ok_q;
  assign frame_drop_cnt = dcnt_q;
  // saturating admitted / dropped frame counters
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      ok_q   <= '0;
      dcnt_q <= '0;
    end else begin
      if (admit && ~&ok_q) ok_q <= ok_q + 32'd1;
      if (drop_d && ~&dcnt_q) dcnt_q <= dcnt_q + 32'd1;
    end
  end
`else
  assign frame_ok_cnt = '0;
  assign frame_drop_cnt = '0;
`endif
endmodule

// File: doc/fifo_frame_wr_ctrl.md
Name: fifo_frame_wr_ctrl

Overview:
- Write-side frame admission controller that feeds the 512x44 async FIFO controller and its RAM from a valid/ready streaming source in the wclk domain.
- Admits a frame only when the FIFO's write water level guarantees room for a maximum-length frame (store-and-forward). Frames that would not fit are dropped.
- Truncates oversize and malformed frames, and packs sop/eop/err flags alongside data into the FIFO word.

Parameters:
- DATA_W, 40, payload width; FIFO word width is DATA_W+4.
- DEPTH_W, 9, FIFO address width; capacity is 2^DEPTH_W words.
- MAX_FRAME_WORDS, 64, largest admitted frame in words; range 1..2^DEPTH_W.

Ports:
- wclk  in  1  write clock.
- wrst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  source word valid.
- s_ready  out  1  source ready; a word transfers when s_valid&s_ready.
- s_data  in  DATA_W  source payload.
- s_sop  in  1  first word of frame.
- s_eop  in  1  last word of frame.
- fifo_wen  out  1  FIFO write enable (w_en of FIFO controller).
- fifo_wdata  out  DATA_W+4  {sop, eop, err, 1'b0, data}.
- fifo_wfull  in  1  FIFO wfull.
- fifo_wr_level  in  DEPTH_W+1  FIFO wr_water_level.
- frame_drop  out  1  one-cycle pulse when a frame is refused at sop.
- proto_err  out  1  one-cycle pulse on a protocol violation (see Behaviour).
- ovf_err  out  1  one-cycle pulse if fifo_wen=1 while fifo_wfull=1.
- frame_ok_cnt  out  32  admitted frames; see Optional Feature.
- frame_drop_cnt  out  32  dropped frames; see Optional Feature.

Behaviour:
- Reset values: state=IDLE; fifo_wen=0; fifo_wdata=0; all pulse outputs=0; counters=0. s_ready=1 while in IDLE.
- Output timing: fifo_wen and fifo_wdata are registered. An accepted word appears exactly 1 cycle after the transfer.
- free = 2^DEPTH_W - fifo_wr_level - fifo_wen, computed in DEPTH_W+2 bits, unsigned. Subtracting fifo_wen covers the write still in flight, because the level includes writes only up to the previous cycle.
- IDLE (s_ready=1):
  - sop word with free >= MAX_FRAME_WORDS: admit. Write the word with sop=1 and the source eop. Set the word count to 1. Go to PASS, or stay in IDLE if eop=1 (single-word frame).
  - sop word with free < MAX_FRAME_WORDS: no write; pulse frame_drop. Go to DROP, or stay in IDLE if eop=1.
  - Non-sop word: discard it and pulse proto_err.
- PASS (s_ready=1): write every accepted word and increment the count.
  - eop: go to IDLE.
  - Word that brings the count to MAX_FRAME_WORDS without eop: write it with eop=1, err=1; pulse proto_err; go to DROP.
  - sop seen in PASS: write that word with sop=0, eop=1, err=1; pulse proto_err; go to DROP. The new frame is discarded.
- DROP (s_ready=1): discard words until eop, then go to IDLE. A sop seen in DROP is also discarded.
- Flow control: s_ready is always 1. Admission guarantees space, so fifo_wfull never back-pressures the source.
- ovf_err is a diagnostic only; the word is lost in the FIFO controller.
- Boundaries:
  - eop together with count==MAX_FRAME_WORDS is a legal full frame, not an error.
  - The word count saturates and never wraps.
  - wrst mid-frame returns to IDLE. A partial frame already written remains in the FIFO; the FIFO is reset alongside it.

Optional Feature:
- FRAME_WR_STATS_EN defined: frame_ok_cnt increments at each admission; frame_drop_cnt increments at each frame_drop pulse. Both are 32-bit and saturate at 0xFFFFFFFF.
- FRAME_WR_STATS_EN undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- fifo_wr_level=448, fifo_wen=0, 64-word frame -> admitted; 64 writes; last word has eop=1, err=0; first fifo_wen 1 cycle after the sop transfer.
- fifo_wr_level=449, sop arrives -> frame_drop pulses once; no fifo_wen for the whole frame; back in IDLE after eop.
- fifo_wr_level=448, fifo_wen=1 on the sop cycle -> free=63; frame dropped.
- 70-word frame, level=0 -> 64 writes; word 64 has eop=1, err=1; proto_err pulses once; words 65-70 discarded.
- Back-to-back single-word frames (sop=eop=1) every cycle, level=0 -> fifo_wen=1 every cycle; each word has sop=1, eop=1.
- With FRAME_WR_STATS_EN: 3 admitted and 2 dropped frames -> frame_ok_cnt=3, frame_drop_cnt=2; without the macro both read 0.
